// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional checksum support is selected with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    CHK,
    DONE,
    ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;

  // States in which the loader takes bytes from the stream.
  function automatic logic accepts_bytes(state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CHK);
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input, instruction-memory write port and core control of the boot loader.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 10
);
  // A byte moves on a rising clk edge where in_valid and in_ready are both high;
  // the source holds in_data stable while in_valid is high and not yet accepted,
  // and in_ready never depends on in_valid in the same cycle.
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              done;
  logic              err;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, err
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, err
  );
endinterface

// File: rtl/imem_boot_loader_word_assembler.sv
// Packs accepted stream bytes little-endian into 32-bit words; flags the
// word as the fourth byte is pushed so the caller can register it.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  din,
  output logic        word_valid,
  output logic [31:0] word
);
  localparam int                 LANE_W    = $clog2(BYTES_PER_WORD);
  localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

  logic [LANE_W-1:0] lane;
  logic [23:0]       low_bytes;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lane      <= '0;
      low_bytes <= '0;
    end else if (push) begin
      lane <= lane + LANE_W'(1);
      case (lane)
        2'd0:    low_bytes[7:0]   <= din;
        2'd1:    low_bytes[15:8]  <= din;
        2'd2:    low_bytes[23:16] <= din;
        default: ;
      endcase
    end
  end

  // The top lane is never stored: it is taken straight from the bus.
  assign word_valid = push && (lane == LAST_LANE);
  assign word       = {din, low_bytes};

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: length-prefixed byte image -> instruction memory, then releases
// the core from reset. IMEM_LOADER_CHECKSUM_EN adds a trailing XOR check byte.
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic   clk,
  input  logic   rst,
  imem_boot_loader_if.slave bus,
  output state_t state_dbg
);
  localparam int DEPTH = 2 ** ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = CHK;
`else
  localparam state_t AFTER_DATA = DONE;
`endif

  state_t            state, state_next;
  logic              in_ready_q, imem_we_q, core_rst_q, done_q, err_q;
  logic [ADDR_W-1:0] imem_addr_q, word_idx;
  logic [31:0]       imem_wdata_q, word;
  logic [7:0]        n_lo;
  logic [15:0]       n_words;
  logic [16:0]       len_full;
  logic              hs, push, word_valid, last_word;

  assign hs        = bus.in_valid & in_ready_q;
  assign push      = hs && (state == DATA);
  assign len_full  = {1'b0, bus.in_data, n_lo};
  assign last_word = (17'(word_idx) + 17'd1) == {1'b0, n_words};

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (state != DATA),
    .push       (push),
    .din        (bus.in_data),
    .word_valid (word_valid),
    .word       (word)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_ok;

  always_ff @(posedge clk) begin
    if (rst)       csum <= 8'h00;
    else if (push) csum <= csum ^ bus.in_data;
  end

  assign csum_ok = (bus.in_data == csum);
`endif

  always_comb begin
    state_next = state;
    case (state)
      LEN_LO: if (hs) state_next = LEN_HI;
      LEN_HI: begin
        if (hs) begin
          if (len_full == 17'd0)            state_next = AFTER_DATA;
          else if (len_full > 17'(DEPTH))   state_next = ERR;
          else                              state_next = DATA;
        end
      end
      DATA: if (word_valid && last_word) state_next = AFTER_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: if (hs) state_next = csum_ok ? DONE : ERR;
`endif
      DONE:    state_next = DONE;
      ERR:     state_next = ERR;
      default: state_next = LEN_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LEN_LO;
      in_ready_q   <= 1'b0;
      n_lo         <= 8'h00;
      n_words      <= 16'h0000;
      word_idx     <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'h0;
      core_rst_q   <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state      <= state_next;
      in_ready_q <= accepts_bytes(state_next);
      if (hs && state == LEN_LO) n_lo    <= bus.in_data;
      if (hs && state == LEN_HI) n_words <= {bus.in_data, n_lo};
      imem_we_q <= word_valid;
      if (word_valid) begin
        imem_addr_q  <= word_idx;
        imem_wdata_q <= word;
        word_idx     <= word_idx + ADDR_W'(1);
      end
      // Release is delayed one cycle so the final write lands before the core runs.
      core_rst_q <= (state != DONE);
      done_q     <= (state == DONE);
      err_q      <= (state_next == ERR);
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.core_rst   = core_rst_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed and randomized image loads into imem_boot_loader (ADDR_W=4),
// with an expected-write queue built from the stream format rules.
module tb_imem_boot_loader;
  import imem_loader_pkg::*;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int EW    = AW + 32;

  logic   clk = 1'b0;
  logic   rst;
  state_t state_dbg;

  always #5 clk = ~clk;

  imem_boot_loader_if #(.ADDR_W(AW)) bus ();

  imem_boot_loader #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int             checks = 0;
  int             errors = 0;
  logic [EW-1:0]  exp_q[$];
  logic [31:0]    img[$];
  logic           we_prev = 1'b0;
  int             writes_seen = 0;
  logic [AW-1:0]  last_addr = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe must match the next expected {addr, word}.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (bus.imem_we === 1'b1) begin
      writes_seen++;
      last_addr = bus.imem_addr;
      e = 'x;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      chk("imem_write", 64'({bus.imem_addr, bus.imem_wdata}), 64'(e));
      chk("we_single_cycle", 64'(we_prev), 64'(0));
    end
    we_prev = bus.imem_we;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input bit exp_we, input int gap);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) chk("ready_timeout", 64'(t), 64'(0));
    @(negedge clk);
    if (exp_we) chk("we_after_lane3", 64'(bus.imem_we), 64'(1));
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      repeat (gap) @(negedge clk);
    end
  endtask

  // Reference: image = N (LE), N words LSB first, optional XOR byte.
  task automatic load_image(input int n, input int gap_mode, input bit corrupt);
    logic [7:0] s[$];
    logic [7:0] x;
    bit         exp_err;
    int         last, g, nd;
    exp_err = (n > DEPTH);
    x = 8'h00;
    for (int k = 0; k < LEN_BYTES; k++) s.push_back(8'(n >> (8 * k)));
    if (!exp_err) begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({AW'(i), img[i]});
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
          s.push_back(8'(img[i] >> (8 * k)));
          x ^= 8'(img[i] >> (8 * k));
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      s.push_back(corrupt ? (x ^ 8'h01) : x);
      exp_err = corrupt;
`endif
    end
    last = s.size() - 1;
    nd   = LEN_BYTES + n * BYTES_PER_WORD;
    for (int j = 0; j <= last; j++) begin
      g = (j == last) ? 0 : ((gap_mode < 0) ? int'($urandom_range(0, 3)) : gap_mode);
      send_byte(s[j], (j >= LEN_BYTES) && (j < nd) &&
                ((j - LEN_BYTES) % BYTES_PER_WORD == BYTES_PER_WORD - 1), g);
    end
    chk("in_ready_after_end", 64'(bus.in_ready), 64'(0));
    chk("core_rst_first", 64'(bus.core_rst), 64'(1));
    chk("done_first", 64'(bus.done), 64'(0));
    chk("err_first", 64'(bus.err), 64'(exp_err));
    bus.in_data = 8'($urandom);
    @(negedge clk);
    chk("core_rst_second", 64'(bus.core_rst), 64'(exp_err));
    chk("done_second", 64'(bus.done), 64'(!exp_err));
    repeat (4) begin
      bus.in_data = 8'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("final_state", 64'(state_dbg), 64'(exp_err ? ERR : DONE));
    chk("err_sticky", 64'(bus.err), 64'(exp_err));
    chk("writes_pending", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int w0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset values
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst_imem_we", 64'(bus.imem_we), 64'(0));
    chk("rst_imem_addr", 64'(bus.imem_addr), 64'(0));
    chk("rst_imem_wdata", 64'(bus.imem_wdata), 64'(0));
    chk("rst_core_rst", 64'(bus.core_rst), 64'(1));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_err", 64'(bus.err), 64'(0));
    chk("rst_state", 64'(state_dbg), 64'(LEN_LO));
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 64'(bus.in_ready), 64'(1));

    // Normal load, back-to-back
    img = '{32'h00A00513, 32'h00B50633};
    w0 = writes_seen;
    load_image(2, 0, 1'b0);
    chk("normal_writes", 64'(writes_seen - w0), 64'(2));

    // Zero length
    do_reset();
    w0 = writes_seen;
    load_image(0, 0, 1'b0);
    chk("zero_len_writes", 64'(writes_seen - w0), 64'(0));

    // Oversize
    do_reset();
    w0 = writes_seen;
    load_image(DEPTH + 1, 0, 1'b0);
    chk("oversize_writes", 64'(writes_seen - w0), 64'(0));

    // Exactly DEPTH words
    do_reset();
    img.delete();
    for (int i = 0; i < DEPTH; i++) img.push_back($urandom);
    w0 = writes_seen;
    load_image(DEPTH, 0, 1'b0);
    chk("full_writes", 64'(writes_seen - w0), 64'(DEPTH));
    chk("full_last_addr", 64'(last_addr), 64'(DEPTH - 1));

    // Gapped stream, same image as the normal load
    do_reset();
    img = '{32'h00A00513, 32'h00B50633};
    w0 = writes_seen;
    load_image(2, 2, 1'b0);
    chk("gapped_writes", 64'(writes_seen - w0), 64'(2));

    // Reset mid-word, then a fresh image from address 0
    do_reset();
    img = '{$urandom, $urandom};
    exp_q.push_back({AW'(0), img[0]});
    send_byte(8'd2, 1'b0, 0);
    send_byte(8'd0, 1'b0, 0);
    for (int k = 0; k < BYTES_PER_WORD; k++)
      send_byte(8'(img[0] >> (8 * k)), k == BYTES_PER_WORD - 1, 0);
    send_byte(8'(img[1]), 1'b0, 0);
    send_byte(8'(img[1] >> 8), 1'b0, 0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_core_rst", 64'(bus.core_rst), 64'(1));
    chk("midrst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("midrst_we", 64'(bus.imem_we), 64'(0));
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_state", 64'(state_dbg), 64'(LEN_LO));
    chk("midrst_in_ready_back", 64'(bus.in_ready), 64'(1));
    chk("midrst_pending", 64'(exp_q.size()), 64'(0));
    img = '{$urandom, $urandom, $urandom};
    load_image(3, -1, 1'b0);

    // Randomized images with random gaps
    for (int r = 0; r < 5; r++) begin
      int n;
      do_reset();
      n = int'($urandom_range(1, 6));
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom);
      load_image(n, -1, 1'b0);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Corrupted checksum keeps the core in reset
    do_reset();
    img = '{32'h00A00513, 32'h00B50633};
    load_image(2, 0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
